// File: rtl/imul_seq_if.sv
// Start/done handshake bundle between a controller and the imul_seq multiplier.
// The iSigned request bit exists only when SIGNED_MUL_EN is defined.
interface imul_seq_if #(
  parameter int WIDTH = 4
);
  logic                   iStart;
  logic [WIDTH-1:0]       wMulA;
  logic [WIDTH-1:0]       wMulB;
`ifdef SIGNED_MUL_EN
  logic                   iSigned;
`endif
  logic                   oBusy;
  logic                   oDone;
  logic [2*WIDTH-1:0]     rResult;

`ifdef SIGNED_MUL_EN
  modport master (output iStart, wMulA, wMulB, iSigned, input oBusy, oDone, rResult);
  modport slave  (input iStart, wMulA, wMulB, iSigned, output oBusy, oDone, rResult);
`else
  modport master (output iStart, wMulA, wMulB, input oBusy, oDone, rResult);
  modport slave  (input iStart, wMulA, wMulB, output oBusy, oDone, rResult);
`endif
endinterface

// File: rtl/imul_seq.sv
// Sequential shift-add multiplier: WIDTH iterations per product, start/done handshake.
// Optional SIGNED_MUL_EN adds two's-complement operands via sign-magnitude around the unsigned core.
module imul_seq #(
  parameter int WIDTH = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  imul_seq_if.slave  bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [PW-1:0] negate(input logic [PW-1:0] v);
    return ~v + PW'(1);
  endfunction

  state_t           state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    res_q, res_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             op_neg;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;

  // Operand conditioning: magnitudes enter the unsigned core, the product sign is kept aside.
  always_comb begin
    mag_a  = bus.wMulA;
    mag_b  = bus.wMulB;
    op_neg = 1'b0;
`ifdef SIGNED_MUL_EN
    if (bus.iSigned) begin
      mag_a  = magnitude(bus.wMulA);
      mag_b  = magnitude(bus.wMulB);
      op_neg = bus.wMulA[WIDTH-1] ^ bus.wMulB[WIDTH-1];
    end
`endif
  end

  assign addend  = b_q[0] ? a_q : '0;
  assign acc_sum = acc_q + addend;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    neg_d   = neg_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.iStart) begin
          a_d     = {{WIDTH{1'b0}}, mag_a};
          b_d     = mag_b;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = op_neg;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        // Final iteration: the result includes this cycle's partial product.
        if (cnt_q == LAST) begin
          res_d   = neg_q ? negate(acc_sum) : acc_sum;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
    end
  end

  assign bus.oBusy   = (state_q == ST_CALC);
  assign bus.oDone   = (state_q == ST_DONE);
  assign bus.rResult = res_q;

endmodule

// File: tb/tb_imul_seq.sv
// Scoreboard bench for imul_seq: WIDTH=4 directed and random, WIDTH=8 random sweep.
module tb_imul_seq;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imul_seq_if #(.WIDTH(4)) bus4();
  imul_seq_if #(.WIDTH(8)) bus8();

  imul_seq #(.WIDTH(4)) u4 (.Clock(clk), .Reset(rst), .bus(bus4));
  imul_seq #(.WIDTH(8)) u8 (.Clock(clk), .Reset(rst), .bus(bus8));

  typedef struct {
    longint res;
    int     cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  // Reference: integer product of the (optionally two's-complement) operands, truncated to 2*w bits.
  function automatic longint model(input longint a, input longint b, input int w, input bit s);
    longint ia, ib, p;
    ia = a;
    ib = b;
    if (s && a[w-1]) ia = a - (longint'(1) << w);
    if (s && b[w-1]) ib = b - (longint'(1) << w);
    p = ia * ib;
    return p & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    check("busy_done_overlap4", longint'(bus4.oBusy & bus4.oDone), 0);
    if (bus4.oDone === 1'b1) begin
      check("done_has_pending4", longint'(q4.size() > 0), 1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check("result4", longint'(bus4.rResult), e.res);
        check("latency4", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    check("busy_done_overlap8", longint'(bus8.oBusy & bus8.oDone), 0);
    if (bus8.oDone === 1'b1) begin
      check("done_has_pending8", longint'(q8.size() > 0), 1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check("result8", longint'(bus8.rResult), e.res);
        check("latency8", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  // Called at a negedge while the DUT is in IDLE or DONE; returns #1 after the accepting edge.
  task automatic issue4(input longint a, input longint b, input bit s, input bit push);
    bus4.wMulA  = a[3:0];
    bus4.wMulB  = b[3:0];
`ifdef SIGNED_MUL_EN
    bus4.iSigned = s;
`endif
    bus4.iStart = 1'b1;
    @(posedge clk);
    #1;
    if (push) q4.push_back('{res: model(a, b, 4, s), cyc: cyc + 4});
    check("busy_after_start4", longint'(bus4.oBusy), 1);
    bus4.iStart = 1'b0;
    bus4.wMulA  = 4'($urandom);
    bus4.wMulB  = 4'($urandom);
  endtask

  task automatic issue8(input longint a, input longint b, input bit s);
    bus8.wMulA  = a[7:0];
    bus8.wMulB  = b[7:0];
`ifdef SIGNED_MUL_EN
    bus8.iSigned = s;
`endif
    bus8.iStart = 1'b1;
    @(posedge clk);
    #1;
    q8.push_back('{res: model(a, b, 8, s), cyc: cyc + 8});
    check("busy_after_start8", longint'(bus8.oBusy), 1);
    bus8.iStart = 1'b0;
    bus8.wMulA  = 8'($urandom);
    bus8.wMulB  = 8'($urandom);
  endtask

  // Leaves the caller at the negedge of the DONE cycle (or after the budget expires).
  task automatic wait_done4();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus4.oDone !== 1'b1 && n < 40);
    check("done_within_budget4", longint'(bus4.oDone), 1);
  endtask

  task automatic wait_done8();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus8.oDone !== 1'b1 && n < 40);
    check("done_within_budget8", longint'(bus8.oDone), 1);
  endtask

  initial begin
    longint a, b;
    bit     s;

    rst = 1'b1;
    bus4.iStart = 1'b0; bus4.wMulA = '0; bus4.wMulB = '0;
    bus8.iStart = 1'b0; bus8.wMulA = '0; bus8.wMulB = '0;
`ifdef SIGNED_MUL_EN
    bus4.iSigned = 1'b0;
    bus8.iSigned = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_result4", longint'(bus4.rResult), 0);
    check("reset_busy4", longint'(bus4.oBusy), 0);
    check("reset_done4", longint'(bus4.oDone), 0);
    check("reset_result8", longint'(bus8.rResult), 0);
    @(negedge clk);
    rst = 1'b0;

    // 3x3 with cycle-by-cycle handshake checks
    @(negedge clk);
    issue4(3, 3, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      check("calc_busy4", longint'(bus4.oBusy), 1);
      check("calc_no_done4", longint'(bus4.oDone), 0);
      @(posedge clk);
      #1;
    end
    check("done_pulse4", longint'(bus4.oDone), 1);
    check("done_not_busy4", longint'(bus4.oBusy), 0);
    check("done_value4", longint'(bus4.rResult), 64'h09);
    @(posedge clk);
    #1;
    check("idle_done_low4", longint'(bus4.oDone), 0);
    check("idle_busy_low4", longint'(bus4.oBusy), 0);
    check("idle_result_held4", longint'(bus4.rResult), 64'h09);

    @(negedge clk); issue4(15, 15, 1'b0, 1'b1); wait_done4();
    @(negedge clk); issue4(0, 13, 1'b0, 1'b1);  wait_done4();
    @(negedge clk); issue4(9, 1, 1'b0, 1'b1);   wait_done4();

    // Back-to-back through DONE, with a stray start pulse mid-calculation
    @(negedge clk);
    issue4(3, 3, 1'b0, 1'b1);
    wait_done4();
    issue4(7, 6, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    bus4.wMulA = 4'd1; bus4.wMulB = 4'd1; bus4.iStart = 1'b1;
    @(negedge clk);
    bus4.iStart = 1'b0;
    check("result_stable_in_calc4", longint'(bus4.rResult), 64'h09);
    wait_done4();
    @(negedge clk);
    check("b2b_idle_after4", longint'(bus4.oBusy | bus4.oDone), 0);
    check("b2b_result_held4", longint'(bus4.rResult), 64'h2A);

    // Reset during the second CALC cycle discards the operation
    issue4(15, 15, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_result4", longint'(bus4.rResult), 0);
    check("abort_busy4", longint'(bus4.oBusy), 0);
    check("abort_done4", longint'(bus4.oDone), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_result_stays4", longint'(bus4.rResult), 0);

`ifdef SIGNED_MUL_EN
    issue4(13, 5, 1'b1, 1'b1);  wait_done4();
    @(negedge clk); issue4(8, 8, 1'b1, 1'b1);   wait_done4();
    @(negedge clk); issue4(7, 15, 1'b1, 1'b1);  wait_done4();
    @(negedge clk); issue4(13, 3, 1'b0, 1'b1);  wait_done4();
    @(negedge clk);
`endif

    // Random WIDTH=4, mixing back-to-back and idle gaps
    for (int i = 0; i < 200; i++) begin
      a = longint'($urandom_range(0, 15));
      b = longint'($urandom_range(0, 15));
`ifdef SIGNED_MUL_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      issue4(a, b, s, 1'b1);
      wait_done4();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Random WIDTH=8 sweep
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      a = longint'($urandom_range(0, 255));
      b = longint'($urandom_range(0, 255));
`ifdef SIGNED_MUL_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      issue8(a, b, s);
      wait_done8();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("drained4", longint'(q4.size()), 0);
    check("drained8", longint'(q8.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
